// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared types and helpers for the neural-net inference sequencer.
//   ctrl_state_t : sequencer FSM encoding
//   width_for(n) : bits needed to hold the values 0..n-1 (never less than 1)
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    SETTLE = 3'd4,
    OUTPUT = 3'd5
  } ctrl_state_t;

  function automatic int unsigned width_for(input int unsigned n);
    int unsigned w;
    if (n <= 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/nn_vec_fifo.sv
// nn_vec_fifo: synchronous FIFO holding queued input vectors.
//   clk, rst  : clock, asynchronous active-high reset (empties the queue)
//   push      : write wr_data (ignored while full)
//   pop       : drop the head entry (ignored while empty)
//   wr_data   : vector to enqueue
//   full      : occupancy == DEPTH (from the registered count)
//   empty     : occupancy == 0 (from the registered count)
//   head      : oldest queued vector; no bypass from wr_data
module nn_vec_fifo
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = width_for(DEPTH);
  localparam int unsigned CNT_W = width_for(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign head      = mem_q[rd_ptr_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Next-state for storage, pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/nn_inference_ctrl.sv
// nn_inference_ctrl: sequencer in front of the neural_net datapath.
//   in_valid/in_ready/in_data    : input vector stream, buffered in nn_vec_fifo
//   net_in/net_first             : vector and one-cycle start strobe to the network
//   net_done/net_result          : level done from the last hidden layer, argmax result
//   res_valid/res_ready/res_data : result stream, held stable until accepted
//   busy                         : FSM active or vectors queued
//   timeout_err                  : sticky watchdog flag, cleared only by rst
//   infer_count                  : completed inferences, wrapping
module nn_inference_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 64,
  parameter int unsigned RES_WIDTH  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESULT_LAT = 1,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic [IN_WIDTH-1:0]  net_in,
  output logic                 net_first,
  input  logic                 net_done,
  input  logic [RES_WIDTH-1:0] net_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_WIDTH-1:0] res_data,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] infer_count
);

  localparam int unsigned WAIT_W   = width_for(TIMEOUT);
  localparam int unsigned LAT_W    = width_for(RESULT_LAT);
  localparam int unsigned LAT_LAST = (RESULT_LAT > 32'd0) ? (RESULT_LAT - 32'd1) : 32'd0;

  ctrl_state_t          state_q, state_d;
  logic [IN_WIDTH-1:0]  net_in_q, net_in_d;
  logic                 net_first_q, net_first_d;
  logic                 res_valid_q, res_valid_d;
  logic [RES_WIDTH-1:0] res_data_q, res_data_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [CNT_WIDTH-1:0] infer_count_q, infer_count_d;
  logic                 done_q;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;

  logic                 fifo_push_s;
  logic                 fifo_pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [IN_WIDTH-1:0]  fifo_head_s;
  logic                 done_rise_s;

  assign in_ready    = ~fifo_full_s;
  assign fifo_push_s = in_valid & ~fifo_full_s;
  assign fifo_pop_s  = (state_q == LOAD);
  // A done level already high at launch is not a rise: done_q tracks it every cycle.
  assign done_rise_s = net_done & ~done_q;

  assign net_in      = net_in_q;
  assign net_first   = net_first_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign timeout_err = timeout_err_q;
  assign infer_count = infer_count_q;
  assign busy        = (state_q != IDLE) | ~fifo_empty_s;

  nn_vec_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push_s),
    .pop     (fifo_pop_s),
    .wr_data (in_data),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .head    (fifo_head_s)
  );

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    net_in_d      = net_in_q;
    net_first_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    timeout_err_d = timeout_err_q;
    infer_count_d = infer_count_q;
    wait_cnt_d    = wait_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        net_in_d    = fifo_head_s;
        // Registered strobe: high during the START cycle only.
        net_first_d = 1'b1;
        state_d     = START;
      end
      START: begin
        wait_cnt_d = {WAIT_W{1'b0}};
        state_d    = RUN;
      end
      RUN: begin
        if (done_rise_s) begin
          if (RESULT_LAT == 32'd0) begin
            // Result is already valid alongside the done rise: capture now.
            res_data_d    = net_result;
            res_valid_d   = 1'b1;
            infer_count_d = infer_count_q + CNT_WIDTH'(1'b1);
            state_d       = OUTPUT;
          end else begin
            lat_cnt_d = {LAT_W{1'b0}};
            state_d   = SETTLE;
          end
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 32'd1)) begin
          // Hung network: abandon this vector.
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1'b1);
        end
      end
      SETTLE: begin
        if (lat_cnt_q == LAT_W'(LAT_LAST)) begin
          res_data_d    = net_result;
          res_valid_d   = 1'b1;
          infer_count_d = infer_count_q + CNT_WIDTH'(1'b1);
          state_d       = OUTPUT;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1'b1);
        end
      end
      OUTPUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers, done edge tracker and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      net_in_q      <= {IN_WIDTH{1'b0}};
      net_first_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= {RES_WIDTH{1'b0}};
      timeout_err_q <= 1'b0;
      infer_count_q <= {CNT_WIDTH{1'b0}};
      done_q        <= 1'b0;
      wait_cnt_q    <= {WAIT_W{1'b0}};
      lat_cnt_q     <= {LAT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      net_in_q      <= net_in_d;
      net_first_q   <= net_first_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      timeout_err_q <= timeout_err_d;
      infer_count_q <= infer_count_d;
      done_q        <= net_done;
      wait_cnt_q    <= wait_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
    end
  end

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// tb_nn_inference_ctrl: directed self-checking bench for nn_inference_ctrl
// (RESULT_LAT=1, TIMEOUT=1024, CNT_WIDTH=4 so the counter wrap is reachable).
module tb_nn_inference_ctrl;

  localparam int IN_W  = 64;
  localparam int RES_W = 4;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [IN_W-1:0]  net_in;
  logic             net_first;
  logic             net_done;
  logic [RES_W-1:0] net_result;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic             busy;
  logic             timeout_err;
  logic [CW-1:0]    infer_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  nn_inference_ctrl #(
    .IN_WIDTH   (IN_W),
    .RES_WIDTH  (RES_W),
    .FIFO_DEPTH (4),
    .RESULT_LAT (1),
    .TIMEOUT    (1024),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .net_in      (net_in),
    .net_first   (net_first),
    .net_done    (net_done),
    .net_result  (net_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .timeout_err (timeout_err),
    .infer_count (infer_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_first(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (net_first === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_res(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (res_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; net_done = 1'b0;
    net_result = '0; res_ready = 1'b0;
    #1;
    tests_run++;
    if ({res_valid, net_first, timeout_err, busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got rv/nf/te/busy=%b expected 0000",
               {res_valid, net_first, timeout_err, busy});
    end
    tests_run++;
    if (net_in !== 64'd0 || res_data !== 4'd0 || infer_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got net_in=%h res_data=%0d count=%0d expected 0",
               net_in, res_data, infer_count);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
  endtask

  task automatic test_single();
    logic [63:0] vec = 64'h0123_4567_89AB_CDEF;
    int first_cnt = 0;
    int first_edge = -1;
    int rv_edge = -1;
    logic [63:0] net_in_at2 = '0;
    in_valid = 1'b1; in_data = vec;
    tick();                       // edge 0: push
    in_valid = 1'b0; in_data = '0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (net_first === 1'b1) begin
        first_cnt++;
        first_edge = e;
      end
      if (e == 2) net_in_at2 = net_in;
      if (e == 10) begin
        net_done = 1'b1;
        net_result = 4'd7;
      end
      if (res_valid === 1'b1 && rv_edge < 0) rv_edge = e;
    end
    tests_run++;
    if (first_cnt != 1 || first_edge != 2) begin
      tests_failed++;
      $display("FAIL single_first: got %0d pulses last at %0d expected 1 at 2", first_cnt, first_edge);
    end
    tests_run++;
    if (net_in_at2 !== vec) begin
      tests_failed++;
      $display("FAIL single_net_in: got %h expected %h", net_in_at2, vec);
    end
    tests_run++;
    if (rv_edge != 12) begin
      tests_failed++;
      $display("FAIL single_latency: got res_valid at %0d expected 12", rv_edge);
    end
    tests_run++;
    if (res_data !== 4'd7 || infer_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL single_result: got data=%0d count=%0d expected 7/1", res_data, infer_count);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; net_done = 1'b0;
    tests_run++;
    if (res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_handshake: got res_valid=%b expected 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v [5];
    int accepted = 0;
    bit early = 1'b0;
    logic [63:0] early_in = '0;
    bit ok;
    bit seen;
    logic [63:0] got;
    v[0] = 64'hA0A0_0000_0000_0001; v[1] = 64'hB1B1_0000_0000_0002;
    v[2] = 64'hC2C2_0000_0000_0003; v[3] = 64'hD3D3_0000_0000_0004;
    v[4] = 64'hE4E4_0000_0000_0005;
    for (int c = 0; c < 8 && accepted < 5; c++) begin
      in_valid = 1'b1; in_data = v[accepted];
      ok = in_ready;
      tick();
      if (ok) accepted++;
      if (net_first === 1'b1 && !early) begin
        early = 1'b1;
        early_in = net_in;
      end
    end
    in_valid = 1'b0; in_data = '0;
    tests_run++;
    if (accepted != 5) begin
      tests_failed++;
      $display("FAIL b2b_accept: got %0d accepted expected 5", accepted);
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_full: got in_ready=%b expected 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0 && early) begin
        seen = 1'b1; got = early_in;
      end else begin
        wait_first(20, seen); got = net_in;
      end
      tests_run++;
      if (!seen || got !== v[i]) begin
        tests_failed++;
        $display("FAIL b2b_order%0d: got seen=%b net_in=%h expected %h", i, seen, got, v[i]);
      end
      tick();
      net_done = 1'b1; net_result = 4'(i + 1);
      wait_res(10, seen);
      tests_run++;
      if (!seen || res_data !== 4'(i + 1)) begin
        tests_failed++;
        $display("FAIL b2b_result%0d: got seen=%b data=%0d expected %0d", i, seen, res_data, i + 1);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0; net_done = 1'b0;
    end
    tests_run++;
    if (infer_count !== 4'd6) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d expected 6", infer_count);
    end
  endtask

  // Ends with a launch in RUN and 3 vectors still queued.
  task automatic test_output_stall();
    logic [63:0] vb [4];
    bit seen;
    int nf = 0;
    int unstable = 0;
    logic nf1, nf2;
    vb[0] = 64'h1000_0000_0000_00AA; vb[1] = 64'h2000_0000_0000_00BB;
    vb[2] = 64'h3000_0000_0000_00CC; vb[3] = 64'h4000_0000_0000_00DD;
    in_valid = 1'b1; in_data = 64'h5555_AAAA_5555_AAAA;
    tick();
    in_valid = 1'b0;
    wait_first(10, seen);
    tick();
    net_done = 1'b1; net_result = 4'd9;
    wait_res(10, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL stall_result: got no res_valid expected res_valid within 10 cycles");
    end
    for (int k = 0; k < 20; k++) begin
      if (k < 4) begin
        in_valid = 1'b1; in_data = vb[k];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (net_first === 1'b1) nf++;
      if (res_valid !== 1'b1 || res_data !== 4'd9) unstable++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (nf != 0 || unstable != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d launches %0d unstable cycles expected 0/0", nf, unstable);
    end
    tests_run++;
    if (in_ready !== 1'b0 || infer_count !== 4'd7) begin
      tests_failed++;
      $display("FAIL stall_fill: got in_ready=%b count=%0d expected 0/7", in_ready, infer_count);
    end
    res_ready = 1'b1;
    tick();                       // handshake edge H
    res_ready = 1'b0; net_done = 1'b0;
    tests_run++;
    if (res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_handshake: got res_valid=%b expected 0", res_valid);
    end
    tick(); nf1 = net_first;
    tick(); nf2 = net_first;
    tests_run++;
    if (nf1 !== 1'b0 || nf2 !== 1'b1 || net_in !== vb[0]) begin
      tests_failed++;
      $display("FAIL stall_relaunch: got nf(H+1,H+2)=%b%b net_in=%h expected 01 %h",
               nf1, nf2, net_in, vb[0]);
    end
    tick();                       // now in RUN
  endtask

  task automatic test_reset_mid();
    int nf = 0;
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({res_valid, net_first, timeout_err, busy} !== 4'b0000 || net_in !== 64'd0 ||
        infer_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got rv/nf/te/busy=%b net_in=%h count=%0d expected 0",
               {res_valid, net_first, timeout_err, busy}, net_in, infer_count);
    end
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_release: got in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (net_first === 1'b1) nf++;
    end
    tests_run++;
    if (nf != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_launch: got %0d launches expected 0", nf);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int te_edge = -1;
    bit rv_seen = 1'b0;
    net_done = 1'b1;
    tick(); tick();
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    in_valid = 1'b0;
    wait_first(10, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL timeout_launch: got no net_first expected launch");
    end
    for (int c = 1; c <= 1030; c++) begin
      tick();
      if (timeout_err === 1'b1 && te_edge < 0) te_edge = c;
      if (res_valid === 1'b1) rv_seen = 1'b1;
    end
    tests_run++;
    if (te_edge != 1025) begin
      tests_failed++;
      $display("FAIL timeout_edge: got timeout_err at %0d expected 1025 (RUN entered at 1)", te_edge);
    end
    tests_run++;
    if (rv_seen || infer_count !== 4'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_state: got rv_seen=%b count=%0d busy=%b expected 0/0/0",
               rv_seen, infer_count, busy);
    end
    net_done = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    bit s1, s2;
    int misses = 0;
    logic [CW-1:0] c16 = '1;
    for (int n = 1; n <= 17; n++) begin
      in_valid = 1'b1; in_data = 64'(n);
      tick();
      in_valid = 1'b0;
      wait_first(10, s1);
      tick();
      net_done = 1'b1; net_result = 4'(n);
      wait_res(10, s2);
      if (!s1 || !s2) misses++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0; net_done = 1'b0;
      if (n == 16) c16 = infer_count;
    end
    tests_run++;
    if (misses != 0) begin
      tests_failed++;
      $display("FAIL wrap_runs: got %0d stalled inferences expected 0", misses);
    end
    tests_run++;
    if (c16 !== 4'd0 || infer_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d after 16 and %0d after 17 expected 0/1", c16, infer_count);
    end
    tests_run++;
    if (timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_sticky: got timeout_err=%b expected 1", timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_output_stall();
    test_reset_mid();
    test_timeout();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
